// File: rtl/regset_pkg.sv
// Shared types and constants for the clear-sweep register set.
package regset_pkg;

  // CLEAR zeroes the array one entry per edge; RUN serves normal traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Number of entries addressed by an address of the given width.
  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

  // Widest storage word supported; sliced to the actual word width.
  localparam int unsigned MAX_WORD_BITS = 1024;

  // Word written to every entry by the sweep: grubby 0, data 0.
  localparam logic [MAX_WORD_BITS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regset_bank.sv
// Storage array for the register set: one write port, two registered read
// ports, no reset anywhere so the array maps onto block RAM.
module regset_bank
  import regset_pkg::*;
#(
  parameter int unsigned W         = 33,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                      clk,
  input  logic                      sweep,
  input  logic [ADDR_BITS-1:0]      sweep_addr,
  input  logic                      we,
  input  logic [ADDR_BITS-1:0]      wa,
  input  logic [W-1:0]              wdata,
  input  logic [1:0][ADDR_BITS-1:0] ra,
  output logic [1:0][W-1:0]         rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_BITS);

  logic [W-1:0] mem [DEPTH];

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [W-1:0]         mem_wd;

  // The sweep owns the write port while it runs; otherwise the external port.
  always_comb begin
    mem_we = we;
    mem_wa = wa;
    mem_wd = wdata;
    if (sweep) begin
      mem_we = 1'b1;
      mem_wa = sweep_addr;
      mem_wd = ZERO_WORD[W-1:0];
    end
  end

  // Single write port into the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Two identical read ports, each registering the old (read-first) value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [W-1:0] rdata_q;

    // Registered read of this port's address.
    always_ff @(posedge clk) begin
      rdata_q <= mem[ra[gi]];
    end

    assign rdata[gi] = rdata_q;
  end

endmodule

// File: rtl/regset_sweep.sv
// Register set with a hardware clear sweep: zeroes every entry after reset or
// a clear request, then raises ready. Holds the FSM, sweep counter, bypass
// selection and output zeroing; storage lives in regset_bank.
module regset_sweep
  import regset_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned GRUBBY    = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic                 wg,
  input  logic [ADDR_BITS-1:0] ra1,
  input  logic [ADDR_BITS-1:0] ra2,
  output logic [WIDTH-1:0]     rd1,
  output logic [WIDTH-1:0]     rd2,
  output logic                 rg1,
  output logic                 rg2,
  output logic                 ready
);

  localparam int unsigned W     = WIDTH + GRUBBY;
  localparam int unsigned DEPTH = depth_of(ADDR_BITS);
  localparam int unsigned CW    = ADDR_BITS + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ready_q, ready_d;
  logic                     zero_q, zero_d;
  logic [1:0]               byp_q, byp_d;
  logic [W-1:0]             bypw_q, bypw_d;

  logic                     ext_we;
  logic [W-1:0]             wword;
  logic [1:0][ADDR_BITS-1:0] ra_vec;
  logic [1:0][W-1:0]        bank_rdata;
  logic [1:0][WIDTH-1:0]    rd_vec;
  logic [1:0]               rg_vec;

  assign ra_vec[0] = ra1;
  assign ra_vec[1] = ra2;

  // Stored word: grubby bit on top only when the grubby column exists.
  if (GRUBBY != 0) begin : g_wword_gr
    assign wword = {wg, wd};
  end else begin : g_wword_ng
    logic unused_wg;
    assign unused_wg = wg;
    assign wword     = wd;
  end

  // External writes are honoured only once the array is valid.
  assign ext_we = we && (state_q == RUN);

  // Next state, sweep counter, and the registered read-side controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    ready_d = (state_d == RUN);
    // Reads taken on a sweep edge register zero.
    zero_d  = (state_q == CLEAR);
    bypw_d  = wword;
    byp_d   = '0;
    for (int i = 0; i < 2; i++) begin
      byp_d[i] = (BYPASS != 0) && ext_we && (wa == ra_vec[i]);
    end
  end

  // Control state with asynchronous reset back into a fresh sweep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      zero_q  <= 1'b1;
      byp_q   <= '0;
      bypw_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      zero_q  <= zero_d;
      byp_q   <= byp_d;
      bypw_q  <= bypw_d;
    end
  end

  regset_bank #(
    .W         (W),
    .ADDR_BITS (ADDR_BITS)
  ) u_bank (
    .clk        (clk),
    .sweep      (state_q == CLEAR),
    .sweep_addr (cnt_q[ADDR_BITS-1:0]),
    .we         (ext_we),
    .wa         (wa),
    .wdata      (wword),
    .ra         (ra_vec),
    .rdata      (bank_rdata)
  );

  // Per-port output select: forced zero, bypassed write word, or array data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [W-1:0] word;
    assign word = zero_q     ? ZERO_WORD[W-1:0] :
                  byp_q[gi]  ? bypw_q           : bank_rdata[gi];
    assign rd_vec[gi] = word[WIDTH-1:0];
    if (GRUBBY != 0) begin : g_gr
      assign rg_vec[gi] = word[W-1];
    end else begin : g_ng
      assign rg_vec[gi] = 1'b0;
    end
  end

  assign rd1   = rd_vec[0];
  assign rd2   = rd_vec[1];
  assign rg1   = rg_vec[0];
  assign rg2   = rg_vec[1];
  assign ready = ready_q;

endmodule

// File: tb/tb_regset_sweep.sv
// Bench for regset_sweep: three configurations share one stimulus stream
// (defaults, no bypass, small 4x8 without grubby) against an entry-level model.
module tb_regset_sweep;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        clr  = 1'b0;
  logic        we   = 1'b0;
  logic [5:0]  wa   = '0;
  logic [31:0] wd   = '0;
  logic        wg   = 1'b0;
  logic [5:0]  ra1  = '0;
  logic [5:0]  ra2  = '0;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [7:0]  rd1_c, rd2_c;
  logic        rg1_a, rg2_a, rg1_b, rg2_b, rg1_c, rg2_c;
  logic        ready_a, ready_b, ready_c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regset_sweep #(.WIDTH(32), .ADDR_BITS(6), .GRUBBY(1), .BYPASS(1)) dut_a (
    .clk(clk), .rstn(rstn), .clr(clr), .we(we), .wa(wa), .wd(wd), .wg(wg),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a), .rg1(rg1_a), .rg2(rg2_a),
    .ready(ready_a));

  regset_sweep #(.WIDTH(32), .ADDR_BITS(6), .GRUBBY(1), .BYPASS(0)) dut_b (
    .clk(clk), .rstn(rstn), .clr(clr), .we(we), .wa(wa), .wd(wd), .wg(wg),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b), .rg1(rg1_b), .rg2(rg2_b),
    .ready(ready_b));

  regset_sweep #(.WIDTH(8), .ADDR_BITS(2), .GRUBBY(0), .BYPASS(1)) dut_c (
    .clk(clk), .rstn(rstn), .clr(clr), .we(we), .wa(wa[1:0]), .wd(wd[7:0]), .wg(wg),
    .ra1(ra1[1:0]), .ra2(ra2[1:0]), .rd1(rd1_c), .rd2(rd2_c), .rg1(rg1_c), .rg2(rg2_c),
    .ready(ready_c));

  // ---------------- behavioural model ----------------
  int          p_depth [3] = '{64, 64, 4};
  logic [31:0] p_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic        p_gr    [3] = '{1'b1, 1'b1, 1'b0};
  logic        p_byp   [3] = '{1'b1, 1'b0, 1'b1};

  logic [32:0] m_mem   [3][64];
  int          m_left  [3];
  logic        m_ready [3];
  logic [31:0] m_rd1 [3], m_rd2 [3];
  logic        m_rg1 [3], m_rg2 [3];
  int          ma, mr1, mr2;
  logic [31:0] md;
  logic        mg;

  // Entry-level model: a sweep is "DEPTH edges of blindness" after which the
  // whole array is zero; in RUN reads see the pre-edge array unless bypassed.
  always @(posedge clk or negedge rstn) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        m_ready[k] = 1'b0;
        m_left[k]  = p_depth[k];
        m_rd1[k] = '0; m_rd2[k] = '0; m_rg1[k] = 1'b0; m_rg2[k] = 1'b0;
        for (int j = 0; j < 64; j++) m_mem[k][j] = '0;
      end else if (!m_ready[k]) begin
        m_rd1[k] = '0; m_rd2[k] = '0; m_rg1[k] = 1'b0; m_rg2[k] = 1'b0;
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) m_ready[k] = 1'b1;
      end else begin
        ma  = int'(wa)  % p_depth[k];
        mr1 = int'(ra1) % p_depth[k];
        mr2 = int'(ra2) % p_depth[k];
        md  = wd & p_mask[k];
        mg  = wg & p_gr[k];
        if (p_byp[k] && we && ma == mr1) begin m_rd1[k] = md; m_rg1[k] = mg; end
        else begin m_rd1[k] = m_mem[k][mr1][31:0]; m_rg1[k] = m_mem[k][mr1][32]; end
        if (p_byp[k] && we && ma == mr2) begin m_rd2[k] = md; m_rg2[k] = mg; end
        else begin m_rd2[k] = m_mem[k][mr2][31:0]; m_rg2[k] = m_mem[k][mr2][32]; end
        if (we) m_mem[k][ma] = {mg, md};
        if (clr) begin
          m_ready[k] = 1'b0;
          m_left[k]  = p_depth[k];
          for (int j = 0; j < 64; j++) m_mem[k][j] = '0;
        end
      end
    end
  end

  logic [31:0] act_rd1 [3], act_rd2 [3];
  logic        act_rg1 [3], act_rg2 [3], act_rdy [3];

  always_comb begin
    act_rd1[0] = rd1_a;          act_rd2[0] = rd2_a;
    act_rd1[1] = rd1_b;          act_rd2[1] = rd2_b;
    act_rd1[2] = {24'h0, rd1_c}; act_rd2[2] = {24'h0, rd2_c};
    act_rg1[0] = rg1_a; act_rg2[0] = rg2_a; act_rdy[0] = ready_a;
    act_rg1[1] = rg1_b; act_rg2[1] = rg2_b; act_rdy[1] = ready_b;
    act_rg1[2] = rg1_c; act_rg2[2] = rg2_c; act_rdy[2] = ready_c;
  end

  // Every cycle, away from the active edge, all outputs of all DUTs vs model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (act_rdy[k] === m_ready[k] && act_rd1[k] === m_rd1[k] && act_rd2[k] === m_rd2[k] &&
          act_rg1[k] === m_rg1[k] && act_rg2[k] === m_rg2[k]) begin
        n_pass++;
      end else begin
        $display("FAIL cycle dut%0d t=%0t got rdy=%b rd1=%h rd2=%h rg1=%b rg2=%b need rdy=%b rd1=%h rd2=%h rg1=%b rg2=%b",
                 k, $time, act_rdy[k], act_rd1[k], act_rd2[k], act_rg1[k], act_rg2[k],
                 m_ready[k], m_rd1[k], m_rd2[k], m_rg1[k], m_rg2[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=%h", name, got);
    end else begin
      $display("FAIL %s got=%h need=%h", name, got, exp);
    end
  endtask

  initial begin
    int n;
    int n_c;

    // Reset values.
    repeat (3) tick();
    check("reset_ready", {31'h0, ready_a}, 32'h0);
    check("reset_rd1", rd1_a, 32'h0);
    check("reset_rg1", {31'h0, rg1_a}, 32'h0);

    // Reset sweep with a write held on address 5 the whole time.
    we = 1'b1; wa = 6'd5; wd = 32'hDEAD_BEEF; wg = 1'b1; ra1 = 6'd5; ra2 = 6'd5;
    rstn = 1'b1;
    n = 0; n_c = 0;
    while (!ready_a && n < 200) begin
      tick();
      n++;
      if (ready_c && n_c == 0) n_c = n;
    end
    we = 1'b0;
    check("sweep_len_a", n, 64);
    check("sweep_len_c", n_c, 4);
    tick();
    check("read5_after_sweep", rd1_a, 32'h0);

    // Basic write then read.
    we = 1'b1; wa = 6'd7; wd = 32'h1234_5678; wg = 1'b1; ra1 = 6'd0; ra2 = 6'd0;
    tick();
    we = 1'b0; ra1 = 6'd7; ra2 = 6'd8;
    tick();
    check("wr7_rd1", rd1_a, 32'h1234_5678);
    check("wr7_rg1", {31'h0, rg1_a}, 32'h1);
    check("rd8_rd2", rd2_a, 32'h0);
    check("rd8_rg2", {31'h0, rg2_a}, 32'h0);

    // Bypass: entry 3 holds 1, then written with A5A5A5A5 while both ports read it.
    we = 1'b1; wa = 6'd3; wd = 32'h1; wg = 1'b0;
    tick();
    wd = 32'hA5A5_A5A5; wg = 1'b1; ra1 = 6'd3; ra2 = 6'd3;
    tick();
    we = 1'b0;
    check("byp_a_rd1", rd1_a, 32'hA5A5_A5A5);
    check("byp_a_rd2", rd2_a, 32'hA5A5_A5A5);
    check("byp_a_rg1", {31'h0, rg1_a}, 32'h1);
    check("nobyp_b_rd1", rd1_b, 32'h1);
    check("nobyp_b_rd2", rd2_b, 32'h1);
    check("nobyp_b_rg2", {31'h0, rg2_b}, 32'h0);
    tick();
    check("nobyp_b_later", rd1_b, 32'hA5A5_A5A5);

    // Small configuration: 0xFF into entry 3, no grubby column.
    we = 1'b1; wa = 6'd3; wd = 32'h0000_00FF; wg = 1'b1;
    tick();
    we = 1'b0; ra1 = 6'd3;
    tick();
    check("c_rd1_ff", {24'h0, rd1_c}, 32'hFF);
    check("c_rg1_zero", {31'h0, rg1_c}, 32'h0);

    // Fill 1..63 with their index, then request a clear (held 3 edges).
    for (int i = 1; i < 64; i++) begin
      we = 1'b1; wa = 6'(i); wd = 32'(i); wg = i[0];
      tick();
    end
    we = 1'b0; ra1 = 6'd63; ra2 = 6'd62;
    tick();
    check("fill_rd63", rd1_a, 32'd63);
    check("fill_rd62", rd2_a, 32'd62);
    clr = 1'b1;
    tick();
    check("clr_ready_low", {31'h0, ready_a}, 32'h0);
    tick();
    tick();
    clr = 1'b0;
    n = 2;
    while (!ready_a && n < 200) begin
      tick();
      n++;
    end
    check("clr_len", n, 64);
    for (int i = 0; i < 64; i++) begin
      ra1 = 6'(i); ra2 = 6'(63 - i);
      tick();
      if (i == 1)  check("clr_rd1_addr1", rd1_a, 32'h0);
      if (i == 63) check("clr_rd1_addr63", {rg1_a, rd1_a[30:0]}, 32'h0);
    end
    check("c_no_wrap", {31'h0, ready_c}, 32'h1);

    // Reset mid-sweep at sweep edge 20.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (19) tick();
    rstn = 1'b0;
    #1;
    check("midsweep_ready_a", {31'h0, ready_a}, 32'h0);
    check("midsweep_ready_c", {31'h0, ready_c}, 32'h0);
    tick();
    rstn = 1'b1;
    n = 0;
    while (!ready_a && n < 200) begin
      tick();
      n++;
    end
    check("restart_len", n, 64);

    // Reset in RUN with a non-zero read on the outputs.
    we = 1'b1; wa = 6'd9; wd = 32'h77; wg = 1'b1;
    tick();
    we = 1'b0; ra1 = 6'd9;
    tick();
    check("run_rd9", rd1_a, 32'h77);
    rstn = 1'b0;
    #1;
    check("midrun_rd1_zero", rd1_a, 32'h0);
    check("midrun_ready", {31'h0, ready_a}, 32'h0);
    tick();
    rstn = 1'b1;
    repeat (66) tick();
    check("final_ready", {31'h0, ready_a}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1, "watchdog");
  end

endmodule
